// File: rtl/cia_pkg.sv
// cia_pkg: register indices, control-register bit positions and shared
// helpers for the cia_lite peripheral (ports, two timers, interrupt control).
package cia_pkg;

    // Register map (4-bit index)
    localparam logic [3:0] REG_PRA  = 4'h0;
    localparam logic [3:0] REG_PRB  = 4'h1;
    localparam logic [3:0] REG_DDRA = 4'h2;
    localparam logic [3:0] REG_DDRB = 4'h3;
    localparam logic [3:0] REG_TALO = 4'h4;
    localparam logic [3:0] REG_TAHI = 4'h5;
    localparam logic [3:0] REG_TBLO = 4'h6;
    localparam logic [3:0] REG_TBHI = 4'h7;
    localparam logic [3:0] REG_ICR  = 4'hD;
    localparam logic [3:0] REG_CRA  = 4'hE;
    localparam logic [3:0] REG_CRB  = 4'hF;

    // Control register bit positions
    localparam int CR_START     = 0;
    localparam int CR_ONESHOT   = 3;
    localparam int CR_FORCELOAD = 4;
    localparam int CR_INMODE_LO = 5;
    localparam int CR_INMODE_HI = 6;

    // FORCELOAD is a strobe and is never stored
    localparam logic [7:0] CR_STORE_MASK = 8'hEF;

    // ICR bit positions
    localparam int ICR_IR = 7;

    // Timer B input-mode codes
    localparam logic [1:0] INMODE_CE    = 2'b00;
    localparam logic [1:0] INMODE_TA_UF = 2'b10;

    localparam logic [15:0] TIMER_RESET = 16'hFFFF;

    // Timer B source event: every tick, Timer A underflow, or nothing
    function automatic logic timer_src(input logic [1:0] inmode, input logic ta_uf);
        logic src;
        case (inmode)
            INMODE_CE:    src = 1'b1;
            INMODE_TA_UF: src = ta_uf;
            default:      src = 1'b0;
        endcase
        return src;
    endfunction

endpackage

// File: rtl/cia_lite_if.sv
// cia_lite_if: CPU register bus for cia_lite.
//   cs   - chip select, active high
//   we   - 1 = write, 0 = read
//   addr - register index
//   di   - write data
//   dout - combinational read data (named dout because "do" is a reserved word)
interface cia_lite_if;
    logic       cs;
    logic       we;
    logic [3:0] addr;
    logic [7:0] di;
    logic [7:0] dout;

    modport master (output cs, we, addr, di, input  dout);
    modport slave  (input  cs, we, addr, di, output dout);
endinterface

// File: rtl/cia_timer.sv
// cia_timer: one 16-bit down-counting interval timer with reload latch.
//   clk, reset  - clock, asynchronous active-low reset
//   ce          - update enable tick; nothing changes on edges with ce=0
//   evt         - source event for this tick (counts only when START=1)
//   wr_lo/wr_hi - latch byte writes (already qualified with ce)
//   wr_cr       - control register write (already qualified with ce)
//   di          - write data
//   counter     - current count
//   cr          - stored control register (FORCELOAD bit always 0)
//   underflow   - asserted on the edge where the counter passes through 0
module cia_timer
    import cia_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        evt,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic        wr_cr,
    input  logic [7:0]  di,
    output logic [15:0] counter,
    output logic [7:0]  cr,
    output logic        underflow
);

    logic [15:0] latch;
    logic        step;
    logic        forceload;

    assign forceload = wr_cr & di[CR_FORCELOAD];
    assign step      = ce & cr[CR_START] & evt;
    // A force load overrides the underflow entirely: no reload, no flag, no stop
    assign underflow = step & (counter == 16'h0000) & ~forceload;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            latch   <= TIMER_RESET;
            counter <= TIMER_RESET;
            cr      <= 8'h00;
        end else if (ce) begin
            if (wr_lo) latch[7:0]  <= di;
            if (wr_hi) latch[15:8] <= di;

            if (forceload)
                counter <= latch;
            else if (wr_hi && !cr[CR_START])
                counter <= {di, latch[7:0]};   // stopped timer takes the new high byte at once
            else if (underflow)
                counter <= latch;
            else if (step)
                counter <= counter - 16'd1;

            if (wr_cr)
                cr <= di & CR_STORE_MASK;
            else if (underflow && cr[CR_ONESHOT])
                cr[CR_START] <= 1'b0;
        end
    end

endmodule

// File: rtl/cia_lite.sv
// cia_lite: reduced CIA-style peripheral with two 8-bit ports, two 16-bit
// timers (Timer B may cascade from Timer A) and an interrupt controller.
//   clk, reset      - clock, asynchronous active-low reset
//   ce              - phi2 tick; registers change only on edges with ce=1
//   bus             - CPU register bus (cs, we, addr, di, dout)
//   pa_in / pb_in   - external pin levels
//   pa_out / pb_out - port output latches
//   pa_dir / pb_dir - direction registers (1 = output)
//   irq_n           - registered interrupt request, active low
module cia_lite
    import cia_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    cia_lite_if.slave        bus,
    input  logic [7:0]       pa_in,
    input  logic [7:0]       pb_in,
    output logic [7:0]       pa_out,
    output logic [7:0]       pb_out,
    output logic [7:0]       pa_dir,
    output logic [7:0]       pb_dir,
    output logic             irq_n
);

    logic        wr;
    logic        icr_rd;
    logic [1:0]  flags;
    logic [1:0]  mask;
    logic [15:0] ta_cnt, tb_cnt;
    logic [7:0]  cra, crb;
    logic        ta_uf, tb_uf;
    logic        tb_evt;

    assign wr     = bus.cs & bus.we & ce;
    assign icr_rd = bus.cs & ~bus.we & ce & (bus.addr == REG_ICR);
    assign tb_evt = timer_src(crb[CR_INMODE_HI:CR_INMODE_LO], ta_uf);

    cia_timer u_timer_a (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .evt       (1'b1),
        .wr_lo     (wr && bus.addr == REG_TALO),
        .wr_hi     (wr && bus.addr == REG_TAHI),
        .wr_cr     (wr && bus.addr == REG_CRA),
        .di        (bus.di),
        .counter   (ta_cnt),
        .cr        (cra),
        .underflow (ta_uf)
    );

    cia_timer u_timer_b (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .evt       (tb_evt),
        .wr_lo     (wr && bus.addr == REG_TBLO),
        .wr_hi     (wr && bus.addr == REG_TBHI),
        .wr_cr     (wr && bus.addr == REG_CRB),
        .di        (bus.di),
        .counter   (tb_cnt),
        .cr        (crb),
        .underflow (tb_uf)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pa_out <= 8'h00;
            pb_out <= 8'h00;
            pa_dir <= 8'h00;
            pb_dir <= 8'h00;
            flags  <= 2'b00;
            mask   <= 2'b00;
            irq_n  <= 1'b1;
        end else begin
            // irq_n follows the registered flags one edge later, ce or not
            irq_n <= ~|(flags & mask);
            if (ce) begin
                if (wr) begin
                    case (bus.addr)
                        REG_PRA:  pa_out <= bus.di;
                        REG_PRB:  pb_out <= bus.di;
                        REG_DDRA: pa_dir <= bus.di;
                        REG_DDRB: pb_dir <= bus.di;
                        REG_ICR:  mask <= bus.di[ICR_IR] ? (mask | bus.di[1:0])
                                                         : (mask & ~bus.di[1:0]);
                        default:  ;
                    endcase
                end
                // Clear-on-read happens first so a coincident underflow survives
                flags <= (icr_rd ? 2'b00 : flags) | {tb_uf, ta_uf};
            end
        end
    end

    always_comb begin
        bus.dout = 8'h00;
        case (bus.addr)
            REG_PRA:  bus.dout = (pa_out & pa_dir) | (pa_in & ~pa_dir);
            REG_PRB:  bus.dout = (pb_out & pb_dir) | (pb_in & ~pb_dir);
            REG_DDRA: bus.dout = pa_dir;
            REG_DDRB: bus.dout = pb_dir;
            REG_TALO: bus.dout = ta_cnt[7:0];
            REG_TAHI: bus.dout = ta_cnt[15:8];
            REG_TBLO: bus.dout = tb_cnt[7:0];
            REG_TBHI: bus.dout = tb_cnt[15:8];
            REG_ICR:  bus.dout = {|(flags & mask), 5'b00000, flags};
            REG_CRA:  bus.dout = cra;
            REG_CRB:  bus.dout = crb;
            default:  bus.dout = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_cia_lite.sv
// tb_cia_lite: directed self-checking bench for cia_lite.
module tb_cia_lite;

    logic       clk;
    logic       reset;
    logic       ce;
    logic [7:0] pa_in, pb_in;
    logic [7:0] pa_out, pb_out, pa_dir, pb_dir;
    logic       irq_n;

    int checks = 0;
    int passed = 0;

    cia_lite_if bus ();

    cia_lite dut (
        .clk    (clk),
        .reset  (reset),
        .ce     (ce),
        .bus    (bus),
        .pa_in  (pa_in),
        .pb_in  (pb_in),
        .pa_out (pa_out),
        .pb_out (pb_out),
        .pa_dir (pa_dir),
        .pb_dir (pb_dir),
        .irq_n  (irq_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks start and end just after a falling edge.
    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.di = d; ce = 1'b1;
        @(negedge clk);
        bus.cs = 1'b0; bus.we = 1'b0; ce = 1'b0;
    endtask

    // Read without a ce tick: no side effects, no clock edge consumed
    task automatic rd(input logic [3:0] a, output logic [7:0] v);
        bus.cs = 1'b1; bus.we = 1'b0; bus.addr = a; ce = 1'b0;
        #1;
        v = bus.dout;
        bus.cs = 1'b0;
    endtask

    // ICR read with ce=1: clears the flags on the following edge
    task automatic rd_icr_clr(output logic [7:0] v);
        bus.cs = 1'b1; bus.we = 1'b0; bus.addr = 4'hD; ce = 1'b1;
        #1;
        v = bus.dout;
        @(negedge clk);
        bus.cs = 1'b0; ce = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            ce = 1'b1;
            @(negedge clk);
            ce = 1'b0;
        end
    endtask

    task automatic do_reset();
        bus.cs = 1'b0; bus.we = 1'b0; bus.addr = 4'h0; bus.di = 8'h00; ce = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] v;
        do_reset();
        checks++; if (pa_out !== 8'h00 || pa_dir !== 8'h00) $display("FAIL rst_port_a: got out=%h dir=%h expected 00/00", pa_out, pa_dir); else passed++;
        checks++; if (pb_out !== 8'h00 || pb_dir !== 8'h00) $display("FAIL rst_port_b: got out=%h dir=%h expected 00/00", pb_out, pb_dir); else passed++;
        checks++; if (irq_n !== 1'b1) $display("FAIL rst_irq_n: got %b expected 1", irq_n); else passed++;
        rd(4'h4, v); checks++; if (v !== 8'hFF) $display("FAIL rst_talo: got %h expected ff", v); else passed++;
        rd(4'h7, v); checks++; if (v !== 8'hFF) $display("FAIL rst_tbhi: got %h expected ff", v); else passed++;
        rd(4'hD, v); checks++; if (v !== 8'h00) $display("FAIL rst_icr: got %h expected 00", v); else passed++;
        rd(4'hF, v); checks++; if (v !== 8'h00) $display("FAIL rst_crb: got %h expected 00", v); else passed++;
    endtask

    task automatic test_ports();
        logic [7:0] v;
        do_reset();
        pa_in = 8'h3C; pb_in = 8'hC3;
        wr(4'h2, 8'h0F); wr(4'h0, 8'hA5);
        wr(4'h3, 8'hF0); wr(4'h1, 8'h5A);
        checks++; if (pa_out !== 8'hA5 || pa_dir !== 8'h0F) $display("FAIL port_a_latch: got out=%h dir=%h expected a5/0f", pa_out, pa_dir); else passed++;
        rd(4'h0, v); checks++; if (v !== 8'h35) $display("FAIL pra_read: got %h expected 35", v); else passed++;
        rd(4'h1, v); checks++; if (v !== 8'h53) $display("FAIL prb_read: got %h expected 53", v); else passed++;
        wr(4'h9, 8'hFF);
        rd(4'h9, v); checks++; if (v !== 8'h00) $display("FAIL unused_reg: got %h expected 00", v); else passed++;
    endtask

    task automatic test_continuous();
        logic [7:0] v;
        do_reset();
        wr(4'h4, 8'h03); wr(4'h5, 8'h00); wr(4'hE, 8'h01);
        rd(4'h4, v); checks++; if (v !== 8'h03) $display("FAIL cont_load: got %h expected 03", v); else passed++;
        tick(3);
        rd(4'hD, v); checks++; if (v !== 8'h00) $display("FAIL cont_no_uf_yet: got icr=%h expected 00", v); else passed++;
        rd(4'h4, v); checks++; if (v !== 8'h00) $display("FAIL cont_zero: got %h expected 00", v); else passed++;
        tick(1);
        rd(4'hD, v); checks++; if (v !== 8'h01) $display("FAIL cont_uf_flag: got icr=%h expected 01", v); else passed++;
        rd(4'h4, v); checks++; if (v !== 8'h03) $display("FAIL cont_reload: got %h expected 03", v); else passed++;
        rd(4'hE, v); checks++; if (v !== 8'h01) $display("FAIL cont_cra: got %h expected 01", v); else passed++;
        tick(1);
        rd(4'h4, v); checks++; if (v !== 8'h02) $display("FAIL cont_running: got %h expected 02", v); else passed++;
    endtask

    task automatic test_oneshot();
        logic [7:0] v;
        do_reset();
        wr(4'h4, 8'h03); wr(4'h5, 8'h00); wr(4'hE, 8'h09);
        tick(4);
        rd(4'hD, v); checks++; if (v !== 8'h01) $display("FAIL os_uf_flag: got icr=%h expected 01", v); else passed++;
        rd(4'hE, v); checks++; if (v !== 8'h08) $display("FAIL os_cra: got %h expected 08", v); else passed++;
        tick(5);
        rd(4'h4, v); checks++; if (v !== 8'h03) $display("FAIL os_hold: got %h expected 03", v); else passed++;
        rd_icr_clr(v); checks++; if (v !== 8'h01) $display("FAIL os_icr_read: got %h expected 01", v); else passed++;
        rd(4'hD, v); checks++; if (v !== 8'h00) $display("FAIL os_single_uf: got icr=%h expected 00", v); else passed++;
    endtask

    task automatic test_irq();
        logic [7:0] v;
        do_reset();
        wr(4'hD, 8'h81);
        wr(4'h4, 8'h01); wr(4'h5, 8'h00); wr(4'hE, 8'h09);
        tick(2);
        checks++; if (irq_n !== 1'b1) $display("FAIL irq_registered: got %b expected 1", irq_n); else passed++;
        @(negedge clk);
        checks++; if (irq_n !== 1'b0) $display("FAIL irq_asserted: got %b expected 0", irq_n); else passed++;
        rd_icr_clr(v); checks++; if (v !== 8'h81) $display("FAIL irq_icr_read: got %h expected 81", v); else passed++;
        @(negedge clk);
        checks++; if (irq_n !== 1'b1) $display("FAIL irq_released: got %b expected 1", irq_n); else passed++;
        rd(4'hD, v); checks++; if (v !== 8'h00) $display("FAIL irq_flags_cleared: got %h expected 00", v); else passed++;
        // Clearing the mask keeps a new flag from raising the interrupt
        wr(4'hD, 8'h01); wr(4'hE, 8'h09);
        tick(3);
        rd(4'hD, v); checks++; if (v !== 8'h01) $display("FAIL irq_masked_icr: got %h expected 01", v); else passed++;
        checks++; if (irq_n !== 1'b1) $display("FAIL irq_masked: got %b expected 1", irq_n); else passed++;
    endtask

    task automatic test_cascade();
        logic [7:0] v;
        do_reset();
        wr(4'h4, 8'h01); wr(4'h5, 8'h00);
        wr(4'h6, 8'h02); wr(4'h7, 8'h00);
        wr(4'hF, 8'h41); wr(4'hE, 8'h01);
        tick(5);
        rd(4'hD, v); checks++; if (v !== 8'h01) $display("FAIL casc_before: got icr=%h expected 01", v); else passed++;
        rd(4'h6, v); checks++; if (v !== 8'h00) $display("FAIL casc_tb_zero: got %h expected 00", v); else passed++;
        tick(1);
        rd(4'hD, v); checks++; if (v !== 8'h03) $display("FAIL casc_tb_uf: got icr=%h expected 03", v); else passed++;
        rd(4'h6, v); checks++; if (v !== 8'h02) $display("FAIL casc_tb_reload: got %h expected 02", v); else passed++;
        rd(4'hF, v); checks++; if (v !== 8'h41) $display("FAIL casc_crb: got %h expected 41", v); else passed++;
    endtask

    task automatic test_forceload();
        logic [7:0] v;
        do_reset();
        wr(4'h4, 8'h10); wr(4'h5, 8'h00); wr(4'hE, 8'h01);
        tick(2);
        rd(4'h4, v); checks++; if (v !== 8'h0E) $display("FAIL fl_pre: got %h expected 0e", v); else passed++;
        wr(4'hE, 8'h11);
        rd(4'h4, v); checks++; if (v !== 8'h10) $display("FAIL fl_load: got %h expected 10", v); else passed++;
        rd(4'hE, v); checks++; if (v !== 8'h01) $display("FAIL fl_strobe: got %h expected 01", v); else passed++;
        tick(1);
        // TAHI write while running only updates the latch
        wr(4'h5, 8'h01);
        rd(4'h4, v); checks++; if (v !== 8'h0E) $display("FAIL hi_running_lo: got %h expected 0e", v); else passed++;
        rd(4'h5, v); checks++; if (v !== 8'h00) $display("FAIL hi_running_hi: got %h expected 00", v); else passed++;
        wr(4'hE, 8'h10);
        rd(4'h5, v); checks++; if (v !== 8'h01) $display("FAIL fl_new_latch: got %h expected 01", v); else passed++;
    endtask

    task automatic test_reset_midcount();
        logic [7:0] v;
        do_reset();
        wr(4'h2, 8'hFF); wr(4'h0, 8'h5A); wr(4'hD, 8'h81);
        wr(4'h4, 8'h00); wr(4'h5, 8'h00); wr(4'hE, 8'h01);
        tick(2);
        checks++; if (irq_n !== 1'b0) $display("FAIL mid_pre_irq: got %b expected 0", irq_n); else passed++;
        #2;
        reset = 1'b0;
        #1;
        checks++; if (pa_out !== 8'h00 || pa_dir !== 8'h00) $display("FAIL mid_port_a: got out=%h dir=%h expected 00/00", pa_out, pa_dir); else passed++;
        checks++; if (irq_n !== 1'b1) $display("FAIL mid_irq_n: got %b expected 1", irq_n); else passed++;
        rd(4'h4, v); checks++; if (v !== 8'hFF) $display("FAIL mid_talo: got %h expected ff", v); else passed++;
        rd(4'hE, v); checks++; if (v !== 8'h00) $display("FAIL mid_cra: got %h expected 00", v); else passed++;
        @(negedge clk);
        reset = 1'b1;
        tick(3);
        rd(4'h4, v); checks++; if (v !== 8'hFF) $display("FAIL mid_stopped: got %h expected ff", v); else passed++;
        rd(4'hD, v); checks++; if (v !== 8'h00) $display("FAIL mid_icr: got %h expected 00", v); else passed++;
    endtask

    initial begin
        reset = 1'b0; ce = 1'b0;
        pa_in = 8'h00; pb_in = 8'h00;
        bus.cs = 1'b0; bus.we = 1'b0; bus.addr = 4'h0; bus.di = 8'h00;
        @(negedge clk);
        test_reset();
        test_ports();
        test_continuous();
        test_oneshot();
        test_irq();
        test_cascade();
        test_forceload();
        test_reset_midcount();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/cia_lite.md
CIA_LITE -- requirements
Module: cia_lite

Interface
REQ-001 No parameters.
REQ-002 clk  in  1  system clock.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 ce  in  1  one-cycle phi2 tick; all register and timer updates occur only on clk edges where ce=1.
REQ-005 cs  in  1  chip select, active high.
REQ-006 we  in  1  1=CPU write, 0=CPU read; meaningful only when cs=1.
REQ-007 addr  in  4  register index.
REQ-008 di  in  8  CPU write data.
REQ-009 do  out  8  CPU read data, combinational from addr.
REQ-010 pa_in / pb_in  in  8 each  external port pin levels.
REQ-011 pa_out / pb_out  out  8 each  port output latches (PRA/PRB).
REQ-012 pa_dir / pb_dir  out  8 each  direction registers (1=output).
REQ-013 irq_n  out  1  interrupt request, active low, registered.

Function
REQ-014 Register map: 0 PRA, 1 PRB, 2 DDRA, 3 DDRB, 4 TALO, 5 TAHI, 6 TBLO, 7 TBHI, D ICR, E CRA, F CRB; 8-C read 0x00 and ignore writes.
REQ-015 PRA read = (PRA & DDRA) | (pa_in & ~DDRA); same rule for port B.
REQ-016 Timer A and Timer B each have a 16-bit latch and a 16-bit counter; TxLO/TxHI writes go to the latch; TxLO/TxHI reads return the counter.
REQ-017 A TxHI write while the timer is stopped also copies the full latch, including the new high byte, into the counter on the same edge.
REQ-018 CRx bits: 0 START, 3 ONESHOT, 4 FORCELOAD (strobe, always reads 0); CRB bits 6:5 select the source (00 = ce, 10 = Timer A underflow, other codes = no counting); all other bits are stored and read back.
REQ-019 Counting step: if START=1 and a source event occurs, a counter of 0 underflows; otherwise the counter decrements by 1.
REQ-020 Period = latch+1 source events; latch 0 underflows on every event.
REQ-021 On underflow, the counter reloads from the latch and the ICR flag is set (bit0 for Timer A, bit1 for Timer B).
REQ-022 On underflow with ONESHOT=1, START is cleared on the same edge.
REQ-023 FORCELOAD=1 written to CRx copies the latch into the counter; this takes priority over a decrement or underflow on the same edge.
REQ-024 In cascade mode (CRB 6:5=10), a Timer A underflow and a Timer B step occur on the same edge.
REQ-025 ICR write: if di[7]=1, mask |= di[1:0]; if di[7]=0, mask &= ~di[1:0].
REQ-026 ICR read returns {any(flags&mask), 5'b0, flags[1:0]}.
REQ-027 A read of ICR with cs=1 and ce=1 clears the flags.
REQ-028 If an ICR read coincides with an underflow, the read returns the old flags, and the new flag is set after the clear.
REQ-029 irq_n is registered as ~|(flags & mask) and is updated every clk edge.
REQ-030 Writes require cs=1, we=1 and ce=1; reads have no side effects except REQ-027.

Reset
REQ-031 On reset=0, asynchronously: PRA, PRB, DDRA, DDRB, CRA, CRB, ICR flags and mask = 0; latches and counters = 0xFFFF; irq_n = 1.
REQ-032 Reset asserted mid-count abandons the count; after release, timers remain stopped until START is written.

Structure
REQ-033 Register index constants and CR bit positions belong in the shared package cia_pkg.
REQ-034 One sub-module, cia_timer, instantiated twice; it holds the latch, counter, START/ONESHOT logic and underflow output.

Verification
REQ-035 Write DDRA=0x0F, PRA=0xA5, with pa_in=0x3C -> pa_out=0xA5, pa_dir=0x0F, PRA read=0x35.
REQ-036 TALO=0x03, TAHI=0x00, CRA=0x01 -> underflow on the 4th ce, ICR bit0 set, counter=0x0003 again, timer keeps running.
REQ-037 Same setup with CRA=0x09 (one-shot) -> single underflow, CRA read=0x08, counter holds 0x0003.
REQ-038 ICR write 0x81, then Timer A underflow -> irq_n low one clk later; ICR read=0x81; flags then clear and irq_n returns high.
REQ-039 Timer A latch 1, Timer B latch 2, CRB=0x41, CRA=0x01 -> Timer B underflows on the 6th ce.
REQ-040 Assert reset mid-count -> all outputs at REQ-031 values immediately, no clk edge needed.
